// File: rtl/viterbi_pkg.sv
// Shared sizing helpers and bit-level functions for the Viterbi ACS datapath.
// Imported by every ACS-unit module.
package viterbi_pkg;

    localparam int WB = 2;

    function automatic int state_bits(input int k);
        return k - 1;
    endfunction

    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/viterbi_acs_unit_acs_core.sv
// Saturating add-compare-select; ties keep predecessor 0.
module acs_core
    import viterbi_pkg::*;
#(
    parameter int Wm = 4
) (
    input  logic [Wm-1:0] pm0,
    input  logic [Wm-1:0] pm1,
    input  logic [WB-1:0] bm0,
    input  logic [WB-1:0] bm1,
    output logic          surv,
    output logic [Wm-1:0] pm_new
);

    logic [Wm:0]   sum0;
    logic [Wm:0]   sum1;
    logic [Wm-1:0] cand0;
    logic [Wm-1:0] cand1;

    assign sum0  = {1'b0, pm0} + (Wm+1)'(bm0);
    assign sum1  = {1'b0, pm1} + (Wm+1)'(bm1);
    assign cand0 = sum0[Wm] ? '1 : sum0[Wm-1:0];
    assign cand1 = sum1[Wm] ? '1 : sum1[Wm-1:0];

    assign surv   = (cand1 < cand0);
    assign pm_new = surv ? cand1 : cand0;

endmodule

// File: rtl/viterbi_acs_unit_branch_metric.sv
// Hard-decision Hamming distance between received and expected symbols.
module branch_metric
    import viterbi_pkg::*;
(
    input  logic [1:0]    rx_sym,
    input  logic [1:0]    exp_sym,
    output logic [WB-1:0] bm
);

    assign bm = popcount2(rx_sym ^ exp_sym);

endmodule

// File: rtl/viterbi_acs_unit_expected_bits.sv
// Encoder output symbol for one predecessor state plus the input bit.
// Bit 1 comes from generator 0, bit 0 from generator 1.
module expected_bits
    import viterbi_pkg::*;
#(
    parameter int K = 4,
    parameter int G0_OCT = 'o17,
    parameter int G1_OCT = 'o13,
    localparam int M = state_bits(K)
) (
    input  logic [M-1:0] pred,
    input  logic         b,
    output logic [1:0]   exp_sym
);

    localparam logic [K-1:0] G0M = K'(G0_OCT);
    localparam logic [K-1:0] G1M = K'(G1_OCT);

    logic [K-1:0] sreg;

    assign sreg       = {pred, b};
    assign exp_sym[1] = parity(32'(sreg & G0M));
    assign exp_sym[0] = parity(32'(sreg & G1M));

endmodule

// File: rtl/viterbi_acs_unit.sv
// One-state-per-cycle ACS with a registered result stage and a
// running minimum-metric tracker for traceback start selection.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int K = 4,
    parameter int Wm = 4,
    parameter int G0_OCT = 'o17,
    parameter int G1_OCT = 'o13,
    localparam int M = state_bits(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [M-1:0]  state_idx,
    input  logic [1:0]    rx_sym,
    input  logic [Wm-1:0] pm0,
    input  logic [Wm-1:0] pm1,
    input  logic          best_clear,
    output logic [M-1:0]  p0,
    output logic [M-1:0]  p1,
    output logic          out_valid,
    output logic [Wm-1:0] pm_out,
    output logic          surv,
    output logic [M-1:0]  state_q,
    output logic [Wm-1:0] best_metric,
    output logic [M-1:0]  best_state
);

    logic [1:0]    exp0;
    logic [1:0]    exp1;
    logic [WB-1:0] bm0;
    logic [WB-1:0] bm1;
    logic          surv_c;
    logic [Wm-1:0] pm_new;

    assign p0 = state_idx >> 1;
    assign p1 = p0 | (M'(1) << (M - 1));

    expected_bits #(.K(K), .G0_OCT(G0_OCT), .G1_OCT(G1_OCT)) u_exp0 (
        .pred    (p0),
        .b       (state_idx[0]),
        .exp_sym (exp0)
    );

    expected_bits #(.K(K), .G0_OCT(G0_OCT), .G1_OCT(G1_OCT)) u_exp1 (
        .pred    (p1),
        .b       (state_idx[0]),
        .exp_sym (exp1)
    );

    branch_metric u_bm0 (.rx_sym(rx_sym), .exp_sym(exp0), .bm(bm0));
    branch_metric u_bm1 (.rx_sym(rx_sym), .exp_sym(exp1), .bm(bm1));

    acs_core #(.Wm(Wm)) u_acs (
        .pm0    (pm0),
        .pm1    (pm1),
        .bm0    (bm0),
        .bm1    (bm1),
        .surv   (surv_c),
        .pm_new (pm_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pm_out    <= '0;
            surv      <= 1'b0;
            state_q   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                pm_out  <= pm_new;
                surv    <= surv_c;
                state_q <= state_idx;
            end
        end
    end

    // Strict compare so equal metrics keep the earlier state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_metric <= '1;
            best_state  <= '0;
        end else if (best_clear) begin
            best_metric <= '1;
            best_state  <= '0;
        end else if (in_valid && (pm_new < best_metric)) begin
            best_metric <= pm_new;
            best_state  <= state_idx;
        end
    end

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Directed-vector bench for viterbi_acs_unit with K=4, Wm=4, G0=17, G1=13.
module tb_viterbi_acs_unit;

    localparam int M  = 3;
    localparam int WM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [M-1:0]  state_idx = '0;
    logic [1:0]    rx_sym = '0;
    logic [WM-1:0] pm0 = '0;
    logic [WM-1:0] pm1 = '0;
    logic          best_clear = 1'b0;
    logic [M-1:0]  p0;
    logic [M-1:0]  p1;
    logic          out_valid;
    logic [WM-1:0] pm_out;
    logic          surv;
    logic [M-1:0]  state_q;
    logic [WM-1:0] best_metric;
    logic [M-1:0]  best_state;

    int checks = 0;
    int failures = 0;

    viterbi_acs_unit #(.K(4), .Wm(4), .G0_OCT('o17), .G1_OCT('o13)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .state_idx   (state_idx),
        .rx_sym      (rx_sym),
        .pm0         (pm0),
        .pm1         (pm1),
        .best_clear  (best_clear),
        .p0          (p0),
        .p1          (p1),
        .out_valid   (out_valid),
        .pm_out      (pm_out),
        .surv        (surv),
        .state_q     (state_q),
        .best_metric (best_metric),
        .best_state  (best_state)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input int st, input int rx,
                         input int a, input int b, input logic clr);
        @(negedge clk);
        in_valid   = v;
        state_idx  = M'(st);
        rx_sym     = 2'(rx);
        pm0        = WM'(a);
        pm1        = WM'(b);
        best_clear = clr;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%0b want=0", out_valid);
        end
        checks++;
        if (pm_out !== 4'd0) begin
            failures++;
            $display("FAIL reset_pm_out got=%0d want=0", pm_out);
        end
        checks++;
        if (best_metric !== 4'd15 || best_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_best got=%0d/%0d want=15/0",
                     best_metric, best_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal_select;
        drive(1'b1, 0, 2'b11, 0, 1, 1'b0);
        #1;
        checks++;
        if (p0 !== 3'b000 || p1 !== 3'b100) begin
            failures++;
            $display("FAIL normal_preds got=%b/%b want=000/100", p0, p1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pm_out !== 4'd1 || surv !== 1'b1) begin
            failures++;
            $display("FAIL normal_acs got=%0d/%0b want=1/1", pm_out, surv);
        end
        checks++;
        if (out_valid !== 1'b1 || state_q !== 3'd0) begin
            failures++;
            $display("FAIL normal_regs got=%0b/%0d want=1/0",
                     out_valid, state_q);
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_tie;
        drive(1'b1, 5, 2'b01, 3, 1, 1'b0);
        #1;
        checks++;
        if (p0 !== 3'b010 || p1 !== 3'b110) begin
            failures++;
            $display("FAIL tie_preds got=%b/%b want=010/110", p0, p1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pm_out !== 4'd3 || surv !== 1'b0 || state_q !== 3'd5) begin
            failures++;
            $display("FAIL tie_acs got=%0d/%0b/%0d want=3/0/5",
                     pm_out, surv, state_q);
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_saturation;
        drive(1'b1, 0, 2'b11, 14, 15, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (pm_out !== 4'd15 || surv !== 1'b0) begin
            failures++;
            $display("FAIL saturation got=%0d/%0b want=15/0", pm_out, surv);
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_best_sweep;
        int pm_in [8]    = '{9, 7, 8, 5, 10, 11, 1, 3};
        int want_pm [8]  = '{9, 7, 8, 5, 11, 12, 2, 4};
        logic want_sv [8] = '{1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0};
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            drive(1'b1, s, 2'b00, pm_in[s], pm_in[s], 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (pm_out !== 4'(want_pm[s]) || surv !== want_sv[s]) begin
                failures++;
                $display("FAIL sweep_s%0d got=%0d/%0b want=%0d/%0b",
                         s, pm_out, surv, want_pm[s], want_sv[s]);
            end
        end
        checks++;
        if (best_metric !== 4'd2 || best_state !== 3'd6) begin
            failures++;
            $display("FAIL sweep_best got=%0d/%0d want=2/6",
                     best_metric, best_state);
        end
        drive(1'b1, 6, 2'b00, 1, 1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (best_metric !== 4'd15 || best_state !== 3'd0) begin
            failures++;
            $display("FAIL clear_priority got=%0d/%0d want=15/0",
                     best_metric, best_state);
        end
        drive(1'b1, 0, 2'b11, 0, 1, 1'b0);
        @(posedge clk);
        drive(1'b1, 1, 2'b00, 1, 1, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (best_metric !== 4'd1 || best_state !== 3'd0) begin
            failures++;
            $display("FAIL best_tie got=%0d/%0d want=1/0",
                     best_metric, best_state);
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 3, 2'b00, 5, 5, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || pm_out !== 4'd5) begin
            failures++;
            $display("FAIL gap_load1 got=%0b/%0d want=1/5", out_valid, pm_out);
        end
        drive(1'b0, 2, 2'b11, 12, 12, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || pm_out !== 4'd5 || state_q !== 3'd3) begin
            failures++;
            $display("FAIL gap_hold1 got=%0b/%0d/%0d want=0/5/3",
                     out_valid, pm_out, state_q);
        end
        drive(1'b1, 0, 2'b11, 0, 1, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || pm_out !== 4'd1) begin
            failures++;
            $display("FAIL gap_load2 got=%0b/%0d want=1/1", out_valid, pm_out);
        end
        drive(1'b0, 7, 2'b01, 9, 9, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || pm_out !== 4'd1 || surv !== 1'b1) begin
            failures++;
            $display("FAIL gap_hold2 got=%0b/%0d/%0b want=0/1/1",
                     out_valid, pm_out, surv);
        end
    endtask

    task automatic test_reset_mid_sweep;
        drive(1'b1, 6, 2'b00, 1, 1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pm_out !== 4'd0 ||
            best_metric !== 4'd15 || best_state !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset got=%0b/%0d/%0d/%0d want=0/0/15/0",
                     out_valid, pm_out, best_metric, best_state);
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_normal_select;
        test_tie;
        test_saturation;
        test_best_sweep;
        test_back_to_back;
        test_reset_mid_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
